vdic_serial_alu: RTL and testbench
==================================

Name: vdic_serial_alu

Overview:
Parametrised serial-protocol ALU, successor to the team's fixed-width serial DUT. Operands and a command arrive bit-serially on din while enable_n is low. Operand width and maximum argument count are configurable. The block executes one of five multi-operand operations and returns a serial status word, then a result word, on dout with dout_valid. It sits directly under the testbench top, driven and monitored by the BFM.

Parameters:
DATA_W, 8, width of operand, command and status words (min 4)
MAX_ARGS, 4, maximum operands per frame (min 2)
RES_W, DATA_W+$clog2(MAX_ARGS), result width; derived, not overridable

Ports:
clk  in  1  clock; all activity on rising edge
rst  in  1  synchronous reset, active-high
enable_n  in  1  active-low frame qualifier for din
din  in  1  serial input, sampled when enable_n=0
dout  out  1  serial output, valid only when dout_valid=1
dout_valid  out  1  qualifies dout
busy  out  1  high from frame end until last output bit sent; input ignored while high

Behaviour:
- Reset: with rst=1 at clk edge → state IDLE, dout=0, dout_valid=0, busy=0, arg count=0, shift regs cleared. Reset mid-frame or mid-output aborts the frame; no further output.
- Word format: 1 flag bit then DATA_W payload bits, MSB first (DATA_W+1 clocks/word). Flag 0 = data, flag 1 = command.
- Frame: enable_n held low continuously from first bit of first word to last bit of command word. Data words are stored in order in an arg buffer of MAX_ARGS entries. The command word ends the frame. Opcode = payload[2:0]: 1 ADD, 2 AND, 3 OR, 4 XOR, 5 SUB (arg0 minus all others); all other values are illegal.
- States: IDLE → RECV on first sample with enable_n=0 (busy=0). RECV → CALC on the last bit of the command word. RECV → STATUS on framing error. CALC → STATUS after one cycle per stored arg. STATUS → RESULT after DATA_W+1 bits, unless an error is set, in which case STATUS → IDLE. RESULT → IDLE after RES_W+1 bits.
- enable_n=1 in IDLE: no action. enable_n=1 mid-word, or after a complete data word with no command received: ERR_FRAME, buffer discarded.
- Arithmetic: operands zero-extended to RES_W. ADD is exact (no overflow possible). SUB wraps modulo 2^RES_W and sets NEG when the true result is < 0. Logic ops operate on zero-extended operands.
- Status payload bits: [0] ERR_ARGS (<2 args, or >MAX_ARGS data words; excess words discarded), [1] ERR_OP, [2] ERR_FRAME, [3] NEG. All other bits are 0.
- Output: STATUS begins the cycle after CALC ends (or after the error is detected). It sends flag 1, then the status payload MSB-first. RESULT follows with no gap: flag 0, then RES_W bits MSB-first. dout_valid=1 on every output bit and 0 otherwise. Any error → status word only, no result word.
- Latency: first dout_valid cycle = N_args+1 cycles after the last command bit is sampled.
- Error priority: all applicable bits are reported. ERR_FRAME suppresses calculation.
- Back-to-back frames: a new frame may start the cycle after busy falls. din activity while busy=1 is ignored and flags nothing.

Test Plan:
- DATA_W=8, MAX_ARGS=4. Data 0x10, 0x20, 0x30, then cmd 0x01 → status flag 1 + 0x00. Result flag 0 + 10'h060. First dout_valid 4 cycles after the last cmd bit.
- Data 0xFF×4, ADD → result 10'h3FC, status 0x00. SUB with 0x05, 0x07 → result 10'h3FE, status 0x08.
- Single data 0x12, cmd ADD → status 0x01, no result word, dout_valid low after 9 bits. Six data words, cmd XOR → status 0x01, no result.
- Data 0x0F, 0xF0, cmd 0x07 → status 0x02 only. enable_n raised after 4 bits of the second word → status 0x04.
- rst=1 during RESULT bit 3 → dout_valid=0, busy=0 next cycle. A fresh AND frame (0xF0, 0x3C) → result 10'h030.
- Toggling din and enable_n while busy=1 → output of the current frame is unchanged. A frame started the cycle after busy falls is accepted.

Source files
------------

// File: rtl/vdic_serial_alu.sv
// vdic_serial_alu: bit-serial multi-operand ALU.
// Interface contract: din is sampled on every rising edge where enable_n=0
// and busy=0; dout carries a meaningful bit only in cycles where
// dout_valid=1, and there is no backpressure on the output stream.
module vdic_serial_alu #(
  parameter int DATA_W   = 8,
  parameter int MAX_ARGS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_n,
  input  logic din,
  output logic dout,
  output logic dout_valid,
  output logic busy
);

  localparam int RES_W = DATA_W + $clog2(MAX_ARGS);
  localparam int CNT_W = $clog2(RES_W + 2);
  localparam int ARG_W = $clog2(MAX_ARGS + 1);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_CALC, S_STATUS, S_RESULT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_buf [MAX_ARGS];
  logic [ARG_W-1:0]    r_argc;
  logic [ARG_W-1:0]    r_idx;
  logic                r_over;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_stat;
  logic                r_err;
  logic [RES_W:0]      r_acc;
  logic                r_dout;
  logic                r_dout_valid;

  logic                w_start;
  logic                w_flag;
  logic [DATA_W-1:0]   w_payload;
  logic [2:0]          w_op;
  logic                w_op_err;
  logic                w_args_err;
  logic                w_word_end;
  logic                w_calc_last;
  logic                w_stat_last;
  logic                w_res_last;
  logic [RES_W:0]      w_operand;
  logic [RES_W:0]      w_acc_next;

  // Frame decode helpers; the flag bit sits at the top of r_shift once a word's
  // last payload bit is on din.
  assign w_start     = (r_state == S_IDLE) && !enable_n && !r_dout_valid;
  assign w_flag      = r_shift[DATA_W-1];
  assign w_payload   = {r_shift[DATA_W-2:0], din};
  assign w_op        = w_payload[2:0];
  assign w_op_err    = (w_op == 3'd0) || (w_op > OP_SUB);
  assign w_args_err  = (r_argc < ARG_W'(2)) || r_over;
  assign w_word_end  = (r_state == S_RECV) && !enable_n && (r_cnt == CNT_W'(DATA_W));
  assign w_calc_last = (r_state == S_CALC) && (r_idx == r_argc - ARG_W'(1));
  assign w_stat_last = (r_state == S_STATUS) && (r_cnt == CNT_W'(DATA_W));
  assign w_res_last  = (r_state == S_RESULT) && (r_cnt == CNT_W'(RES_W));
  assign w_operand   = {{(RES_W + 1 - DATA_W){1'b0}}, r_buf[r_idx]};

  // One accumulation step; the extra top bit carries the sign of a SUB result.
  always_comb begin
    w_acc_next = r_acc;
    if (r_idx == '0) begin
      w_acc_next = w_operand;
    end else begin
      case (r_op)
        OP_ADD:  w_acc_next = r_acc + w_operand;
        OP_AND:  w_acc_next = r_acc & w_operand;
        OP_OR:   w_acc_next = r_acc | w_operand;
        OP_XOR:  w_acc_next = r_acc ^ w_operand;
        OP_SUB:  w_acc_next = r_acc - w_operand;
        default: w_acc_next = r_acc;
      endcase
    end
  end

  // Next-state logic for the frame / compute / output sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_RECV;
      S_RECV: begin
        if (enable_n)                w_next = S_STATUS;
        else if (w_word_end && w_flag) w_next = (r_argc == '0) ? S_STATUS : S_CALC;
      end
      S_CALC:   if (w_calc_last) w_next = S_STATUS;
      S_STATUS: if (w_stat_last) w_next = r_err ? S_IDLE : S_RESULT;
      S_RESULT: if (w_res_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: deserialise, buffer operands, accumulate, serialise status/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_argc       <= '0;
      r_idx        <= '0;
      r_over       <= 1'b0;
      r_op         <= '0;
      r_stat       <= '0;
      r_err        <= 1'b0;
      r_acc        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < MAX_ARGS; i++) r_buf[i] <= '0;
    end else begin
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shift <= {{(DATA_W-1){1'b0}}, din};
            r_cnt   <= CNT_W'(1);
            r_argc  <= '0;
            r_over  <= 1'b0;
            r_stat  <= '0;
            r_err   <= 1'b0;
          end
        end
        S_RECV: begin
          if (enable_n) begin
            // Early release of enable_n: drop the buffer, report framing only.
            r_stat <= DATA_W'(4);
            r_err  <= 1'b1;
            r_argc <= '0;
            r_cnt  <= '0;
          end else if (r_cnt == CNT_W'(DATA_W)) begin
            r_cnt <= '0;
            if (w_flag) begin
              r_op   <= w_op;
              r_idx  <= '0;
              r_stat <= {{(DATA_W-2){1'b0}}, w_op_err, w_args_err};
              r_err  <= w_op_err | w_args_err;
            end else if (r_argc == ARG_W'(MAX_ARGS)) begin
              r_over <= 1'b1;
            end else begin
              r_buf[r_argc] <= w_payload;
              r_argc        <= r_argc + ARG_W'(1);
            end
          end else begin
            r_shift <= {r_shift[DATA_W-2:0], din};
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + ARG_W'(1);
          if (w_calc_last && (r_op == OP_SUB)) r_stat[3] <= w_acc_next[RES_W];
        end
        S_STATUS: begin
          r_dout_valid <= 1'b1;
          r_dout       <= (r_cnt == '0) ? 1'b1 : r_stat[DATA_W-1];
          if (r_cnt != '0) r_stat <= r_stat << 1;
          r_cnt <= w_stat_last ? '0 : r_cnt + CNT_W'(1);
        end
        S_RESULT: begin
          r_dout_valid <= 1'b1;
          r_dout       <= (r_cnt == '0) ? 1'b0 : r_acc[RES_W-1];
          if (r_cnt != '0) r_acc <= r_acc << 1;
          r_cnt <= w_res_last ? '0 : r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == S_CALC) || (r_state == S_STATUS) ||
                      (r_state == S_RESULT) || r_dout_valid;

endmodule

// File: tb/tb_vdic_serial_alu.sv
// tb_vdic_serial_alu: directed frames with hand-computed status/result words.
module tb_vdic_serial_alu;

  localparam int DATA_W = 8;
  localparam int RES_W  = 10;

  logic clk;
  logic rst;
  logic enable_n;
  logic din;
  logic dout;
  logic dout_valid;
  logic busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [RES_W:0] exp_q[$];

  vdic_serial_alu #(.DATA_W(DATA_W), .MAX_ARGS(4)) dut (
    .clk(clk), .rst(rst), .enable_n(enable_n), .din(din),
    .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    enable_n = 1'b0;
    din      = b;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic flag, input logic [7:0] payload);
    send_bit(flag);
    for (int i = 7; i >= 0; i--) send_bit(payload[i]);
  endtask

  task automatic push_status(input logic [7:0] s);
    exp_q.push_back(11'({1'b1, s}));
  endtask

  task automatic push_result(input logic [9:0] r);
    exp_q.push_back({1'b0, r});
  endtask

  task automatic wait_done(input bit toggle);
    int k;
    k = 0;
    while (!busy && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("busy_rise", busy, 1);
    k = 0;
    while (busy && k < 400) begin
      if (toggle) begin
        din      = 1'($urandom_range(0, 1));
        enable_n = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; k++;
    end
    check("busy_fall", busy, 0);
    enable_n = 1'b1;
    din      = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] args [8], input int n, input logic [7:0] cmd,
                           input bit toggle, output int lat);
    for (int i = 0; i < n; i++) send_word(1'b0, args[i]);
    send_word(1'b1, cmd);
    enable_n = 1'b1;
    lat = 0;
    while (!dout_valid && lat < 50) begin
      if (toggle) begin
        din      = 1'($urandom_range(0, 1));
        enable_n = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; lat++;
    end
    wait_done(toggle);
  endtask

  // scoreboard monitor: assembles status then result words off dout
  int             mon_cnt = 0;
  bit             mon_res = 1'b0;
  logic [RES_W:0] mon_word;
  logic [RES_W:0] mon_exp;

  always @(negedge clk) begin
    if (rst) begin
      mon_cnt = 0;
      mon_res = 1'b0;
    end else if (dout_valid) begin
      if (mon_cnt == 0) mon_word = '0;
      mon_word = {mon_word[RES_W-1:0], dout};
      mon_cnt++;
      if (mon_cnt == (mon_res ? RES_W + 1 : DATA_W + 1)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got %0h, nothing expected", mon_word);
        end else begin
          mon_exp = exp_q.pop_front();
          check(mon_res ? "result_word" : "status_word", 32'(mon_word), 32'(mon_exp));
        end
        mon_cnt = 0;
        mon_res = !mon_res;
      end
    end else begin
      if (mon_cnt != 0) begin
        n_checks++;
        $display("FAIL truncated_word: got %0d bits, expected a complete word", mon_cnt);
      end
      mon_cnt = 0;
      mon_res = 1'b0;
    end
  end

  // stimulus
  initial begin
    int lat;
    int k;
    int seen;
    rst      = 1'b1;
    enable_n = 1'b1;
    din      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD of three words, latency N_args+1
    push_status(8'h00); push_result(10'h060);
    run_frame('{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 8'h01, 1'b0, lat);
    check("lat_add3", lat, 4);

    // ADD at maximum operand values
    push_status(8'h00); push_result(10'h3FC);
    run_frame('{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 8'h01, 1'b0, lat);

    // SUB going negative
    push_status(8'h08); push_result(10'h3FE);
    run_frame('{8'h05, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'h05, 1'b0, lat);
    check("lat_sub2", lat, 3);

    // SUB positive, three operands
    push_status(8'h00); push_result(10'h050);
    run_frame('{8'h80, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 8'h05, 1'b0, lat);

    // SUB most negative: 0 - 3*255 wraps to 0x103
    push_status(8'h08); push_result(10'h103);
    run_frame('{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 8'h05, 1'b0, lat);

    // XOR
    push_status(8'h00); push_result(10'h0F0);
    run_frame('{8'hAA, 8'h55, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 8'h04, 1'b0, lat);

    // too few args: single word, then command only
    push_status(8'h01);
    run_frame('{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 8'h01, 1'b0, lat);
    push_status(8'h01);
    run_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h01, 1'b0, lat);

    // too many args
    push_status(8'h01);
    run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00}, 6, 8'h04, 1'b0, lat);

    // illegal opcode
    push_status(8'h02);
    run_frame('{8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'h07, 1'b0, lat);

    // enable_n released mid-word
    push_status(8'h04);
    send_word(1'b0, 8'h0F);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    enable_n = 1'b1;
    wait_done(1'b0);

    // enable_n released after a complete data word, no command
    push_status(8'h04);
    send_word(1'b0, 8'h33);
    enable_n = 1'b1;
    wait_done(1'b0);

    // reset during the result word
    push_status(8'h00);
    send_word(1'b0, 8'h10); send_word(1'b0, 8'h20); send_word(1'b0, 8'h30);
    send_word(1'b1, 8'h01);
    enable_n = 1'b1;
    k = 0;
    while (!dout_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("pre_rst_valid", dout_valid, 1);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_busy", busy, 0);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (dout_valid) seen++;
    end
    check("no_out_after_rst", seen, 0);

    // fresh AND frame after reset
    push_status(8'h00); push_result(10'h030);
    run_frame('{8'hF0, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'h02, 1'b0, lat);

    // inputs toggled while busy, then a frame the cycle after busy falls
    push_status(8'h00); push_result(10'h003);
    run_frame('{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'h01, 1'b1, lat);
    push_status(8'h00); push_result(10'h0FF);
    run_frame('{8'h0F, 8'h30, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 8'h03, 1'b0, lat);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
